// File: rtl/reg_tx_pkg.sv
// Shared types and line-level constants for the register serial transmitter.
package reg_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/reg_tx_bit_timer.sv
// Counts CLK cycles within one serial bit; bit_tick marks the last cycle of each bit.
module reg_tx_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reg8_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, WIDTH data bits LSB-first, stop bit.
module reg8_serial_tx
  import reg_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             bit_tick;

  // Holding the timer cleared in IDLE makes every frame start on a fresh count.
  reg_tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .CLK      (CLK),
    .reset    (reset),
    .clr      (state == IDLE),
    .bit_tick (bit_tick)
  );

  assign shift_nxt = shift >> 1;

  // Outputs are registered alongside the state so tx_out reflects the state it belongs to.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      tx_out     <= LINE_IDLE;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            state      <= START;
            shift      <= D;
            bit_cnt    <= '0;
            tx_out     <= START_BIT;
            load_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_out  <= shift[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
              state  <= STOP;
              tx_out <= STOP_BIT;
            end else begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + BW'(1);
              tx_out  <= shift_nxt[0];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            state      <= IDLE;
            tx_out     <= LINE_IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          tx_out     <= LINE_IDLE;
          load_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg8_serial_tx.sv
// Directed bench for reg8_serial_tx: a BIT_CYCLES=4 instance and a BIT_CYCLES=1 instance.
module tb_reg8_serial_tx;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d_a = '0, d_b = '0;
  logic       lv_a = 1'b0, lv_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  reg8_serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .CLK(CLK), .reset(reset), .D(d_a), .load_valid(lv_a),
    .load_ready(ready_a), .tx_out(tx_a), .busy(busy_a), .done(done_a)
  );

  reg8_serial_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut_b (
    .CLK(CLK), .reset(reset), .D(d_b), .load_valid(lv_b),
    .load_ready(ready_b), .tx_out(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame bit k: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return w[k-1];
  endfunction

  // Entered at the negedge of the first cycle after the accepting edge; leaves in the done cycle.
  task automatic expect_frame(input string tag, input logic [7:0] w);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_tx"}, tx_a, frame_bit(w, k));
        chk({tag, "_busy"}, busy_a, 1);
        chk({tag, "_nodone"}, done_a, 0);
        @(negedge CLK);
      end
    end
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_idle_tx"}, tx_a, 1);
    chk({tag, "_idle_busy"}, busy_a, 0);
    chk({tag, "_idle_ready"}, ready_a, 1);
  endtask

  task automatic accept_a(input logic [7:0] w);
    @(negedge CLK);
    d_a  = w;
    lv_a = 1'b1;
    chk("acc_ready", ready_a, 1);
    @(negedge CLK);
    lv_a = 1'b0;
  endtask

  initial begin
    logic saw_done;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_ready_b", ready_b, 1);
    reset = 1'b0;

    // Single frame A5
    accept_a(8'hA5);
    expect_frame("t1", 8'hA5);
    @(negedge CLK);
    chk("t1_done_once", done_a, 0);

    // D ignored mid-frame, plus backpressure with a word changing before acceptance
    accept_a(8'h3C);
    fork
      expect_frame("t2", 8'h3C);
      begin
        repeat (10) @(negedge CLK);
        d_a = 8'hFF;
        chk("t6_ready_busy", ready_a, 0);
        repeat (10) @(negedge CLK);
        lv_a = 1'b1;
        chk("t6_ready_held", ready_a, 0);
        repeat (10) @(negedge CLK);
        d_a = 8'h5A;
      end
    join
    @(negedge CLK);
    lv_a = 1'b0;
    expect_frame("t6", 8'h5A);

    // Back-to-back with load_valid held
    @(negedge CLK);
    d_a  = 8'h01;
    lv_a = 1'b1;
    @(negedge CLK);
    d_a = 8'h80;
    chk("t3_ready_low", ready_a, 0);
    expect_frame("t3a", 8'h01);
    @(negedge CLK);
    lv_a = 1'b0;
    expect_frame("t3b", 8'h80);

    // Reset during data bit 3
    accept_a(8'hF0);
    repeat (17) @(negedge CLK);
    chk("t4_bit3", tx_a, 0);
    #1 reset = 1'b1;
    #1;
    chk("t4_async_tx", tx_a, 1);
    chk("t4_async_busy", busy_a, 0);
    chk("t4_async_ready", ready_a, 1);
    chk("t4_async_done", done_a, 0);
    @(negedge CLK);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge CLK);
      if (done_a) saw_done = 1'b1;
    end
    chk("t4_no_done", saw_done, 0);
    accept_a(8'h0F);
    expect_frame("t4", 8'h0F);

    // BIT_CYCLES=1 instance
    @(negedge CLK);
    d_b  = 8'h55;
    lv_b = 1'b1;
    chk("t5_ready", ready_b, 1);
    @(negedge CLK);
    lv_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t5_tx", tx_b, frame_bit(8'h55, k));
      chk("t5_busy", busy_b, 1);
      chk("t5_nodone", done_b, 0);
      @(negedge CLK);
    end
    chk("t5_done", done_b, 1);
    chk("t5_idle_tx", tx_b, 1);
    @(negedge CLK);
    chk("t5_done_once", done_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
